// File: rtl/nibble_seq_adder.sv
// rtl/nibble_seq_adder.sv - nibble-serial operand sequencer and result collector around an external 4-bit adder
// Optional subtract mode (op_sub port, operand B inversion) is enabled by defining NIBADD_SUB_EN.
module nibble_seq_adder #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
`ifdef NIBADD_SUB_EN
  input  logic         op_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_c,
  input  logic [3:0]   add_s,
  input  logic         add_co,
  output logic         busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic [IW-1:0]  r_idx;

  logic [3:0]     w_a_nib;
  logic [3:0]     w_b_nib;
  logic           w_last;
  logic           w_run;
  logic [W-1:0]   w_b_in;
  logic           w_c_in;

`ifdef NIBADD_SUB_EN
  // Subtraction as A + ~B + 1; the incoming carry is forced so op_cin is ignored.
  assign w_b_in = op_sub ? ~op_b : op_b;
  assign w_c_in = op_sub ? 1'b1 : op_cin;
`else
  assign w_b_in = op_b;
  assign w_c_in = op_cin;
`endif

  always_comb begin
    w_a_nib = 4'd0;
    w_b_nib = 4'd0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_nib = r_a[4*k +: 4];
        w_b_nib = r_b[4*k +: 4];
      end
    end
  end

  assign w_last = (r_idx == IW'(NIBBLES - 1));
  assign w_run  = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IW'(k)) r_sum[4*k +: 4] <= add_s;
          end
          r_carry <= add_co;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout  <= add_co;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = ~in_ready;
  assign sum       = r_sum;
  assign cout      = r_cout;
  // Adder inputs are held at zero outside RUN so the ripple path stays quiet.
  assign add_a     = w_run ? w_a_nib : 4'd0;
  assign add_b     = w_run ? w_b_nib : 4'd0;
  assign add_c     = w_run & r_carry;

endmodule

// File: tb/tb_nibble_seq_adder.sv
// tb/tb_nibble_seq_adder.sv - self-checking bench for nibble_seq_adder with NIBBLES=4
// Define NIBADD_SUB_EN to also exercise subtract mode.
module tb_nibble_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
`ifdef NIBADD_SUB_EN
  logic        op_sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_c;
  logic [3:0]  add_s;
  logic        add_co;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [3:0] rec_a [0:31];
  logic       rec_c [0:31];
  int         nrec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment stand-in for the external 4-bit ripple-carry adder.
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_c};

  nibble_seq_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef NIBADD_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_s(add_s), .add_co(add_co),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
    logic [16:0] r;
    if (sub) begin
      r[15:0] = a - b;
      r[16]   = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    end
    return r;
  endfunction

  // Offers one operand pair, records the adder drive each RUN cycle, returns result and latency.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, output logic [15:0] s, output logic c, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    op_a = a;
    op_b = b;
    op_cin = cin;
`ifdef NIBADD_SUB_EN
    op_sub = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
    in_valid = 1'b1;
    nrec = 0;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      op_a = 16'hDEAD;
      op_b = 16'hBEEF;
      if (out_valid) begin
        lat = nrec;
        break;
      end
      rec_a[nrec] = add_a;
      rec_c[nrec] = add_c;
      nrec++;
    end
    s = sum;
    c = cout;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
  } vec_t;

  vec_t        vt [6];
  logic [15:0] rs;
  logic        rc;
  int          lat;
  logic [16:0] exp_r;
  logic [16:0] res [$];
  int          acc_t [2];
  int          nacc;
  logic        acc_now;
  logic [15:0] ra, rb;
  logic        rcin, rsub;

  initial begin
    vt[0] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vt[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vt[5] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
`ifdef NIBADD_SUB_EN
    op_sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum_cout", {15'd0, cout, sum}, 32'd0);
    check("rst_add", {23'd0, add_a, add_b, add_c}, 32'd0);

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, 1'b0, rs, rc, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd4);
      check($sformatf("vec%0d_sum", i), {16'd0, rs}, {16'd0, vt[i].s});
      check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vt[i].c});
      if (i == 1 && nrec >= 4) begin
        for (int k = 1; k < 4; k++) begin
          check($sformatf("ripple_add_c%0d", k), {31'd0, rec_c[k]}, 32'd1);
          check($sformatf("ripple_add_a%0d", k), {28'd0, rec_a[k]}, 32'hF);
        end
      end
    end

    // Output backpressure with ignored in_valid pulses.
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_sum", {15'd0, cout, sum}, 32'h05555);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = i[0];
      op_a = 16'hAAAA; op_b = 16'h1111;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset during the second RUN cycle.
    op_a = 16'h1111; op_b = 16'h2222; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, rs, rc, lat);
    check("postrst_sum", {15'd0, rc, rs}, 32'h01000);

`ifdef NIBADD_SUB_EN
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rc, lat);
    check("sub_7_5", {15'd0, rc, rs}, 32'h10002);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, lat);
    check("sub_5_7", {15'd0, rc, rs}, 32'h0FFFE);
`endif

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rcin = 1'($urandom);
`ifdef NIBADD_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      exp_r = ref_model(ra, rb, rcin, rsub);
      run_op(ra, rb, rcin, rsub, rs, rc, lat);
      check($sformatf("rand%0d_%h_%h_%0d_%0d", i, ra, rb, rcin, rsub),
            {15'd0, rc, rs}, {15'd0, exp_r});
      check($sformatf("rand%0d_latency", i), lat, 32'd4);
    end

    // Back-to-back throughput with out_ready held high.
    @(negedge clk);
    out_ready = 1'b1;
    op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0;
`ifdef NIBADD_SUB_EN
    op_sub = 1'b0;
`endif
    in_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 40 && res.size() < 2; i++) begin
      if (out_valid) res.push_back({cout, sum});
      acc_now = in_valid && in_ready;
      if (acc_now && nacc < 2) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
      if (acc_now && nacc == 1) begin
        op_a = 16'hABCD; op_b = 16'h1234;
      end
      if (acc_now && nacc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", nacc, 32'd2);
    check("b2b_results", res.size(), 32'd2);
    if (nacc == 2) check("b2b_spacing", acc_t[1] - acc_t[0], 32'd6);
    if (res.size() == 2) begin
      check("b2b_res0", {15'd0, res[0]}, 32'h03333);
      check("b2b_res1", {15'd0, res[1]}, 32'h0BE01);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
